// File: rtl/multi_line_window_buffer.sv
// KERNEL+1 line memories in a ring, filled from a ready/valid pixel stream and
// presenting a KERNEL x KERNEL window with wrap or clamp handling at the right edge.
module multi_line_window_buffer #(
  parameter int PIXEL_SIZE  = 8,
  parameter int IMAGE_WIDTH = 512,
  parameter int KERNEL      = 3,
  parameter int EDGE_MODE   = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [PIXEL_SIZE-1:0]                 i_data,
  input  logic                                  i_data_valid,
  output logic                                  o_data_ready,
  output logic [PIXEL_SIZE*KERNEL*KERNEL-1:0]   o_window,
  output logic                                  o_window_valid,
  input  logic                                  i_window_ready,
  output logic                                  o_line_done,
  output logic [$clog2(KERNEL+2)-1:0]           o_fill_count
);

  localparam int NUM_LINES = KERNEL + 1;
  localparam int LINE_W    = $clog2(NUM_LINES);
  localparam int COL_W     = $clog2(IMAGE_WIDTH);
  localparam int FILL_W    = $clog2(KERNEL + 2);

  logic [PIXEL_SIZE-1:0] line_mem [NUM_LINES][IMAGE_WIDTH];

  logic [LINE_W-1:0] wr_line, rd_line;
  logic [COL_W-1:0]  wr_col, rd_col;
  logic [FILL_W-1:0] fill_count;
  logic              line_done;

  logic wr_hs, rd_hs, wr_last, rd_last;

  // Both flow-control outputs come straight from registered state, so neither
  // depends combinationally on the opposite side's handshake input.
  assign o_data_ready   = fill_count < FILL_W'(NUM_LINES);
  assign o_window_valid = fill_count >= FILL_W'(KERNEL);
  assign o_fill_count   = fill_count;
  assign o_line_done    = line_done;

  assign wr_hs   = i_data_valid && o_data_ready;
  assign rd_hs   = o_window_valid && i_window_ready;
  assign wr_last = wr_hs && (wr_col == COL_W'(IMAGE_WIDTH - 1));
  assign rd_last = rd_hs && (rd_col == COL_W'(IMAGE_WIDTH - 1));

  // NOTE: the line memories have no reset; stale contents are never exposed
  // because a window only becomes valid after KERNEL fresh lines are written.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      line_mem[wr_line][wr_col] <= i_data;
    end
  end

  // NOTE: every variable driven here gets a value on every path (o_window is
  // defaulted first), so no latch can be inferred.
  always_comb begin
    o_window = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int j = 0; j < KERNEL; j++) begin
        int row_idx;
        int col_idx;
        row_idx = (int'(rd_line) + r) % NUM_LINES;
        col_idx = int'(rd_col) + j;
        if (col_idx > IMAGE_WIDTH - 1) begin
          col_idx = (EDGE_MODE == 1) ? IMAGE_WIDTH - 1 : col_idx - IMAGE_WIDTH;
        end
        o_window[(KERNEL*KERNEL-1-(r*KERNEL+j))*PIXEL_SIZE +: PIXEL_SIZE] =
          line_mem[LINE_W'(row_idx)][COL_W'(col_idx)];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_line    <= '0;
      wr_col     <= '0;
      rd_line    <= '0;
      rd_col     <= '0;
      fill_count <= '0;
      line_done  <= 1'b0;
    end else begin
      line_done <= rd_last;

      if (wr_hs) begin
        if (wr_last) begin
          wr_col  <= '0;
          wr_line <= (wr_line == LINE_W'(NUM_LINES - 1)) ? '0 : wr_line + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end

      if (rd_hs) begin
        if (rd_last) begin
          rd_col  <= '0;
          rd_line <= (rd_line == LINE_W'(NUM_LINES - 1)) ? '0 : rd_line + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end

      // A line finishing on each side in the same cycle leaves the count as is.
      case ({wr_last, rd_last})
        2'b10:   fill_count <= fill_count + 1'b1;
        2'b01:   fill_count <= fill_count - 1'b1;
        default: fill_count <= fill_count;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_line_window_buffer.sv
// Directed + random bench for multi_line_window_buffer; two instances (wrap and
// clamp edge modes) share stimulus and are compared against an absolute-line image model.
module tb_multi_line_window_buffer;

  localparam int PS = 8;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int NL = K + 1;
  localparam int WW = PS * K * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [PS-1:0] data;
  logic          data_valid;
  logic          window_ready;

  logic          rdy_a, vld_a, done_a;
  logic          rdy_b, vld_b, done_b;
  logic [WW-1:0] win_a, win_b;
  logic [2:0]    fill_a, fill_b;

  multi_line_window_buffer #(.PIXEL_SIZE(PS), .IMAGE_WIDTH(W), .KERNEL(K), .EDGE_MODE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .i_data(data), .i_data_valid(data_valid),
    .o_data_ready(rdy_a), .o_window(win_a), .o_window_valid(vld_a),
    .i_window_ready(window_ready), .o_line_done(done_a), .o_fill_count(fill_a));

  multi_line_window_buffer #(.PIXEL_SIZE(PS), .IMAGE_WIDTH(W), .KERNEL(K), .EDGE_MODE(1)) dut_clamp (
    .clk(clk), .reset_n(reset_n), .i_data(data), .i_data_valid(data_valid),
    .o_data_ready(rdy_b), .o_window(win_b), .o_window_valid(vld_b),
    .i_window_ready(window_ready), .o_line_done(done_b), .o_fill_count(fill_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lines are numbered absolutely since reset; the ring is not modelled.
  logic [PS-1:0] img [128][W];
  int m_wr_line, m_wr_col, m_rd_line, m_rd_col;
  bit m_done;

  function automatic int m_fill();
    return m_wr_line - m_rd_line;
  endfunction

  function automatic logic [WW-1:0] exp_window(input bit clamp);
    logic [WW-1:0] w;
    int c;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int j = 0; j < K; j++) begin
        c = m_rd_col + j;
        if (c > W - 1) c = clamp ? W - 1 : c - W;
        w[(K*K-1-(r*K+j))*PS +: PS] = img[7'((m_rd_line + r) % 128)][3'(c)];
      end
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ready_a", WW'(rdy_a), WW'(m_fill() < NL));
    check("ready_b", WW'(rdy_b), WW'(m_fill() < NL));
    check("valid_a", WW'(vld_a), WW'(m_fill() >= K));
    check("valid_b", WW'(vld_b), WW'(m_fill() >= K));
    check("fill_a",  WW'(fill_a), WW'(m_fill()));
    check("fill_b",  WW'(fill_b), WW'(m_fill()));
    check("done_a",  WW'(done_a), WW'(m_done));
    check("done_b",  WW'(done_b), WW'(m_done));
    if (m_fill() >= K) begin
      check("window_wrap",  win_a, exp_window(1'b0));
      check("window_clamp", win_b, exp_window(1'b1));
    end
  endtask

  // Called at a falling edge; drives, checks, clocks once, returns at the next falling edge.
  task automatic cycle(input bit v, input logic [PS-1:0] d, input bit r);
    bit wr_hs, rd_hs;
    data_valid   = v;
    data         = d;
    window_ready = r;
    check_outputs();
    wr_hs = v && (m_fill() < NL);
    rd_hs = r && (m_fill() >= K);
    @(posedge clk);
    m_done = 1'b0;
    if (wr_hs) begin
      img[7'(m_wr_line % 128)][3'(m_wr_col)] = d;
      if (m_wr_col == W - 1) begin
        m_wr_col = 0;
        m_wr_line++;
      end else begin
        m_wr_col++;
      end
    end
    if (rd_hs) begin
      if (m_rd_col == W - 1) begin
        m_rd_col = 0;
        m_rd_line++;
        m_done = 1'b1;
      end else begin
        m_rd_col++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    data_valid   = 1'b0;
    window_ready = 1'b0;
    @(posedge clk);
    m_wr_line = 0; m_wr_col = 0; m_rd_line = 0; m_rd_col = 0; m_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic stream_lines(input int first_row, input int rows);
    for (int row = first_row; row < first_row + rows; row++)
      for (int col = 0; col < W; col++)
        cycle(1'b1, PS'(row * 16 + col), 1'b0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b1; data = '0; data_valid = 1'b0; window_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_ready", WW'(rdy_a), WW'(1));
    check("rst_valid", WW'(vld_a), WW'(0));
    check("rst_fill",  WW'(fill_a), WW'(0));
    check("rst_done",  WW'(done_a), WW'(0));

    // 1: three lines, window appears after pixel 23
    stream_lines(0, 3);
    check("first_valid",  WW'(vld_a), WW'(1));
    check("first_fill",   WW'(fill_a), WW'(3));
    check("first_window", win_a, 72'h000102101112202122);

    // 2: one full row of transfers, edge handling at column 6
    for (int i = 0; i < W; i++) begin
      if (i == 6) begin
        check("wrap_row0",  WW'(win_a[71:48]), WW'(24'h060700));
        check("clamp_row0", WW'(win_b[71:48]), WW'(24'h060707));
      end
      cycle(1'b0, '0, 1'b1);
    end
    check("row_done",    WW'(done_a), WW'(1));
    check("row_fill",    WW'(fill_a), WW'(2));
    check("row_valid",   WW'(vld_a), WW'(0));

    // 3: fill the ring, then offer pixels that must be held off
    stream_lines(3, 2);
    check("full_ready", WW'(rdy_a), WW'(0));
    check("full_fill",  WW'(fill_a), WW'(4));
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < W; i++) cycle(1'b0, '0, 1'b1);
    check("release_ready", WW'(rdy_a), WW'(1));
    check("release_row0",  WW'(win_a[71:48]), WW'(24'h202122));

    // 4: last write of line 5 coincides with last read of a row
    for (int col = 0; col < W; col++) cycle(1'b1, PS'(5 * 16 + col), 1'b1);
    check("align_fill",   WW'(fill_a), WW'(3));
    check("align_done",   WW'(done_a), WW'(1));
    check("align_window", win_a, 72'h303132404142505152);

    // 5: random traffic on both sides
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), PS'($urandom), 1'($urandom_range(0, 1)));

    // 6: reach fill_count=3 with the writer mid-row, then reset for one cycle
    guard = 0;
    while (!(m_fill() == 3 && m_wr_col == 3) && guard < 100) begin
      cycle(1'b1, PS'($urandom), m_fill() == NL);
      guard++;
    end
    check("reach_mid_row", WW'(guard < 100), WW'(1));
    do_reset();
    check("mid_rst_valid", WW'(vld_a), WW'(0));
    check("mid_rst_fill",  WW'(fill_a), WW'(0));
    check("mid_rst_ready", WW'(rdy_a), WW'(1));
    stream_lines(0, 3);
    check("restart_window", win_a, 72'h000102101112202122);
    check("restart_fill",   WW'(fill_a), WW'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
